// File: rtl/msrv32_wb_pipe_unit_if.sv
// Writeback stage handshake bundle: the upstream entry side (execute -> stage)
// and the downstream entry side (stage -> register file).
//
// Handshake: an entry moves across a boundary on a rising clock edge where
// valid and ready are both high. A producer holds valid and its payload
// steady until that edge. The stage drives in_ready_out from a register, so
// it never depends combinationally on out_ready_in.
interface msrv32_wb_pipe_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = 3
);
  // Upstream (execute) side
  logic                    in_valid_in;
  logic                    in_ready_out;
  logic [SEL_W-1:0]        wb_mux_sel_in;
  logic [NUM_SRC*XLEN-1:0] src_data_in;
  logic [4:0]              rd_addr_in;
  logic                    rd_wr_en_in;

  // Downstream (register file) side
  logic                    out_valid_out;
  logic                    out_ready_in;
  logic [XLEN-1:0]         wb_data_out;
  logic [4:0]              wb_rd_addr_out;
  logic                    wb_wr_en_out;

  // Stage view
  modport slave (
    input  in_valid_in, wb_mux_sel_in, src_data_in, rd_addr_in, rd_wr_en_in,
    input  out_ready_in,
    output in_ready_out,
    output out_valid_out, wb_data_out, wb_rd_addr_out, wb_wr_en_out
  );

  // Environment view: drives upstream entries and the register-file ready
  modport master (
    output in_valid_in, wb_mux_sel_in, src_data_in, rd_addr_in, rd_wr_en_in,
    output out_ready_in,
    input  in_ready_out,
    input  out_valid_out, wb_data_out, wb_rd_addr_out, wb_wr_en_out
  );
endinterface

// File: rtl/msrv32_wb_pipe_unit.sv
// msrv32 writeback stage: selects the writeback value from NUM_SRC result
// sources when an entry is accepted, then holds it in a two-entry
// (main + skid) buffer that feeds the register file in FIFO order.
// Also hosts the ALU second-operand mux as a purely combinational side path
// and a sticky flag for select codes outside the populated source range.
module msrv32_wb_pipe_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = 3
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic            flush_in,
  msrv32_wb_pipe_unit_if.slave wb_if,
  input  logic            alu_source_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  output logic [XLEN-1:0] alu_2nd_src_out,
  output logic            illegal_sel_out
);

  // One buffered writeback entry; the select code itself is not kept.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q,   in_ready_d;
  logic   illegal_q,    illegal_d;

  logic   accept;
  logic   transfer;
  logic   sel_illegal;
  logic [XLEN-1:0] sel_data;

  assign accept   = wb_if.in_valid_in & in_ready_q;
  assign transfer = main_valid_q & wb_if.out_ready_in;

  // Writeback source mux; codes without a source fall back to source 0.
  always_comb begin
    sel_data    = wb_if.src_data_in[0 +: XLEN];
    sel_illegal = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (wb_if.wb_mux_sel_in == SEL_W'(k)) begin
        sel_data    = wb_if.src_data_in[k*XLEN +: XLEN];
        sel_illegal = 1'b0;
      end
    end
  end

  assign new_entry = '{data: sel_data, rd: wb_if.rd_addr_in, we: wb_if.rd_wr_en_in};

  // Buffer next state: flush, then accept/transfer combinations, oldest first.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    // A dropped (flushed) entry still reports a bad select code.
    illegal_d    = illegal_q | (accept & sel_illegal);

    if (flush_in) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || transfer)) begin
      if (skid_valid_q) begin
        // Skid is older than the new entry, so it advances first.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end
    end else if (accept) begin
      // Main is stalled by the register file: park the entry in the skid.
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end else if (transfer) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // Ready is registered so it carries no path from out_ready_in.
    in_ready_d = ~skid_valid_d;
  end

  // Buffer state registers.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      illegal_q    <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      illegal_q    <= illegal_d;
    end
  end

  // Outputs: writes to x0 still handshake but never strobe the register file.
  assign wb_if.in_ready_out   = in_ready_q;
  assign wb_if.out_valid_out  = main_valid_q;
  assign wb_if.wb_data_out    = main_q.data;
  assign wb_if.wb_rd_addr_out = main_q.rd;
  assign wb_if.wb_wr_en_out   = main_valid_q & main_q.we & (main_q.rd != 5'd0);
  assign illegal_sel_out      = illegal_q;

  // ALU operand B mux, independent of the buffer and of reset.
  assign alu_2nd_src_out = alu_source_in ? rs2_in : imm_in;

endmodule

// File: tb/tb_msrv32_wb_pipe_unit.sv
// Directed bench for msrv32_wb_pipe_unit: a driver pushes each accepted
// entry's expected writeback into exp_q; an independent monitor pops and
// compares whenever the register file side completes a transfer.
module tb_msrv32_wb_pipe_unit;
  localparam int XLEN    = 32;
  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 3;
  localparam int W       = XLEN + 5 + 1;

  logic clk;
  logic rst_n;
  logic flush;
  logic alu_source;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_2nd;
  logic illegal_sel;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  msrv32_wb_pipe_unit_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) wb_if ();

  msrv32_wb_pipe_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .flush_in               (flush),
    .wb_if                  (wb_if.slave),
    .alu_source_in          (alu_source),
    .rs2_in                 (rs2),
    .imm_in                 (imm),
    .alu_2nd_src_out        (alu_2nd),
    .illegal_sel_out        (illegal_sel)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Source k = base + k*step
  function automatic logic [NUM_SRC*XLEN-1:0] mk_src(input logic [XLEN-1:0] base,
                                                      input logic [XLEN-1:0] step);
    logic [NUM_SRC*XLEN-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_SRC; k++) v[k*XLEN +: XLEN] = base + XLEN'(k) * step;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Offers one entry from posedge+1 and returns at posedge+1 after acceptance.
  task automatic send(input logic [SEL_W-1:0] sel, input logic [NUM_SRC*XLEN-1:0] src,
                      input logic [4:0] rd, input logic we, input logic [XLEN-1:0] exp_data);
    int waited;
    logic ok;
    wb_if.in_valid_in   = 1'b1;
    wb_if.wb_mux_sel_in = sel;
    wb_if.src_data_in   = src;
    wb_if.rd_addr_in    = rd;
    wb_if.rd_wr_en_in   = we;
    waited = 0;
    ok     = 1'b0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (wb_if.in_ready_out === 1'b1) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check("send_timeout", 64'(waited), 64'd0);
    end else begin
      exp_q.push_back({exp_data, rd, we && (rd != 5'd0)});
    end
    @(posedge clk); #1;
    wb_if.in_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_if.out_valid_out === 1'b1 && wb_if.out_ready_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'({wb_if.wb_data_out, wb_if.wb_rd_addr_out, wb_if.wb_wr_en_out}), 64'h0);
        n_fail += (n_checks > 0 && {wb_if.wb_data_out, wb_if.wb_rd_addr_out, wb_if.wb_wr_en_out} == '0) ? 1 : 0;
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wb_entry", 64'({wb_if.wb_data_out, wb_if.wb_rd_addr_out, wb_if.wb_wr_en_out}), 64'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n               = 1'b0;
    flush               = 1'b0;
    alu_source          = 1'b0;
    rs2                 = '0;
    imm                 = '0;
    wb_if.in_valid_in   = 1'b0;
    wb_if.wb_mux_sel_in = '0;
    wb_if.src_data_in   = '0;
    wb_if.rd_addr_in    = '0;
    wb_if.rd_wr_en_in   = 1'b0;
    wb_if.out_ready_in  = 1'b0;

    // Reset state and ALU mux while reset is held
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(wb_if.out_valid_out), 64'd0);
    check("rst_in_ready", 64'(wb_if.in_ready_out), 64'd1);
    check("rst_wr_en", 64'(wb_if.wb_wr_en_out), 64'd0);
    check("rst_illegal", 64'(illegal_sel), 64'd0);
    check("rst_wb_data", 64'(wb_if.wb_data_out), 64'd0);
    check("rst_wb_rd", 64'(wb_if.wb_rd_addr_out), 64'd0);
    rs2 = 32'hA5A5A5A5; imm = 32'h00000FFF; alu_source = 1'b1;
    #1 check("alu_rs2_in_reset", 64'(alu_2nd), 64'hA5A5A5A5);
    alu_source = 1'b0;
    #1 check("alu_imm_in_reset", 64'(alu_2nd), 64'h00000FFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU mux out of reset
    alu_source = 1'b1;
    #1 check("alu_rs2", 64'(alu_2nd), 64'hA5A5A5A5);
    alu_source = 1'b0;
    #1 check("alu_imm", 64'(alu_2nd), 64'h00000FFF);
    @(posedge clk); #1;

    // 1) Back-to-back accepts, full throughput
    wb_if.out_ready_in = 1'b1;
    send(3'd0, mk_src(32'h11, 32'h11), 5'd1, 1'b1, 32'h11);
    check("latency_out_valid", 64'(wb_if.out_valid_out), 64'd1);
    send(3'd1, mk_src(32'h11, 32'h11), 5'd2, 1'b1, 32'h22);
    check("b2b_in_ready", 64'(wb_if.in_ready_out), 64'd1);
    send(3'd2, mk_src(32'h11, 32'h11), 5'd3, 1'b1, 32'h33);
    send(3'd3, mk_src(32'h11, 32'h11), 5'd4, 1'b1, 32'h44);
    check("b2b_in_ready_end", 64'(wb_if.in_ready_out), 64'd1);
    drain();

    // 2) Backpressure fills main and skid; third entry waits upstream
    wb_if.out_ready_in = 1'b0;
    send(3'd1, mk_src(32'h1000, 32'h100), 5'd6, 1'b1, 32'h1100);
    send(3'd4, mk_src(32'h1000, 32'h100), 5'd7, 1'b1, 32'h1400);
    check("bp_in_ready_low", 64'(wb_if.in_ready_out), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_still_not_ready", 64'(wb_if.in_ready_out), 64'd0);
    check("bp_main_head", 64'(wb_if.wb_data_out), 64'h1100);
    wb_if.out_ready_in = 1'b1;
    send(3'd5, mk_src(32'h1000, 32'h100), 5'd8, 1'b0, 32'h1500);
    drain();

    // 3) Illegal select captures source 0 and sets the sticky flag
    send(3'd7, mk_src(32'hDEADBEEF, 32'h1), 5'd9, 1'b1, 32'hDEADBEEF);
    drain();
    check("illegal_set", 64'(illegal_sel), 64'd1);
    send(3'd2, mk_src(32'hDEADBEEF, 32'h1), 5'd10, 1'b1, 32'hDEADBEF1);
    drain();
    check("illegal_sticky", 64'(illegal_sel), 64'd1);

    // 4a) Skid full, flush together with a new offer
    wb_if.out_ready_in = 1'b0;
    send(3'd0, mk_src(32'h2000, 32'h10), 5'd11, 1'b1, 32'h2000);
    send(3'd1, mk_src(32'h2000, 32'h10), 5'd12, 1'b1, 32'h2010);
    flush = 1'b1;
    wb_if.in_valid_in   = 1'b1;
    wb_if.wb_mux_sel_in = 3'd2;
    wb_if.src_data_in   = mk_src(32'h3000, 32'h10);
    @(posedge clk); #1;
    flush = 1'b0;
    wb_if.in_valid_in = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 64'(wb_if.out_valid_out), 64'd0);
    check("flush_in_ready", 64'(wb_if.in_ready_out), 64'd1);

    // 4b) Flush wins over an accept in the same cycle
    send(3'd3, mk_src(32'h4000, 32'h10), 5'd13, 1'b1, 32'h4030);
    flush = 1'b1;
    wb_if.in_valid_in   = 1'b1;
    wb_if.wb_mux_sel_in = 3'd4;
    wb_if.src_data_in   = mk_src(32'h5000, 32'h10);
    @(posedge clk); #1;
    flush = 1'b0;
    wb_if.in_valid_in = 1'b0;
    exp_q.delete();
    check("flush_accept_out_valid", 64'(wb_if.out_valid_out), 64'd0);
    wb_if.out_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("flush_nothing_appears", 64'(wb_if.out_valid_out), 64'd0);

    // 5) x0 writes handshake without a write strobe
    wb_if.out_ready_in = 1'b0;
    send(3'd0, mk_src(32'h6000, 32'h1), 5'd0, 1'b1, 32'h6000);
    check("x0_out_valid", 64'(wb_if.out_valid_out), 64'd1);
    check("x0_wr_en", 64'(wb_if.wb_wr_en_out), 64'd0);
    wb_if.out_ready_in = 1'b1;
    drain();
    wb_if.out_ready_in = 1'b0;
    send(3'd0, mk_src(32'h6000, 32'h1), 5'd5, 1'b1, 32'h6000);
    check("rd5_wr_en", 64'(wb_if.wb_wr_en_out), 64'd1);
    check("rd5_addr", 64'(wb_if.wb_rd_addr_out), 64'd5);
    wb_if.out_ready_in = 1'b1;
    drain();

    // 6) Reset mid-stream drops entries and clears the flag
    wb_if.out_ready_in = 1'b0;
    send(3'd1, mk_src(32'h7000, 32'h1), 5'd14, 1'b1, 32'h7001);
    send(3'd2, mk_src(32'h7000, 32'h1), 5'd15, 1'b1, 32'h7002);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(wb_if.out_valid_out), 64'd0);
    check("midrst_wr_en", 64'(wb_if.wb_wr_en_out), 64'd0);
    check("midrst_in_ready", 64'(wb_if.in_ready_out), 64'd1);
    check("midrst_illegal_clear", 64'(illegal_sel), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 7) Flushed entry with an illegal select still sets the flag
    wb_if.out_ready_in  = 1'b1;
    flush               = 1'b1;
    wb_if.in_valid_in   = 1'b1;
    wb_if.wb_mux_sel_in = 3'd6;
    wb_if.src_data_in   = mk_src(32'h8000, 32'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    wb_if.in_valid_in = 1'b0;
    check("flush_illegal_set", 64'(illegal_sel), 64'd1);
    check("flush_illegal_dropped", 64'(wb_if.out_valid_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/msrv32_wb_pipe_unit.md
Name: msrv32_wb_pipe_unit

Overview:
Parametrised, registered writeback stage for the msrv32 core. It selects the writeback value from NUM_SRC result sources and carries it with the destination register address. A 2-entry skid buffer with valid/ready handshaking sits between execute and the register file. It also provides the ALU second-operand mux as a combinational side path, and raises a sticky error flag on an illegal select code.

Parameters:
XLEN, 32, data width of every source, the immediate, rs2 and writeback data
NUM_SRC, 6, number of writeback sources (legal range 2..8); source order 0=ALU, 1=LU, 2=IMM, 3=IADDER, 4=CSR, 5=PC+4, 6..7=spare
SEL_W, 3, width of the select field; must satisfy 2**SEL_W >= NUM_SRC

Ports:
ms_riscv32_mp_clk_in  input  1  core clock, rising edge
ms_riscv32_mp_rst_n_in  input  1  asynchronous, active-low reset
flush_in  input  1  discard all buffered entries
in_valid_in  input  1  upstream entry valid
in_ready_out  output  1  stage can accept an entry
wb_mux_sel_in  input  SEL_W  writeback source select
src_data_in  input  NUM_SRC*XLEN  packed sources; source k occupies bits [k*XLEN +: XLEN]
rd_addr_in  input  5  destination register
rd_wr_en_in  input  1  instruction writes rd
out_valid_out  output  1  writeback entry valid
out_ready_in  input  1  register file accepts entry
wb_data_out  output  XLEN  selected writeback data
wb_rd_addr_out  output  5  destination register
wb_wr_en_out  output  1  qualified register-file write strobe
alu_source_in  input  1  1 selects rs2, 0 selects the immediate
rs2_in  input  XLEN  rs2 operand
imm_in  input  XLEN  immediate operand
alu_2nd_src_out  output  XLEN  ALU second operand (combinational)
illegal_sel_out  output  1  sticky flag: a select code >= NUM_SRC was accepted

Behaviour:
- Reset (async assert, sync release): main and skid valid bits = 0; data and address registers = 0; illegal_sel_out = 0; in_ready_out = 1; out_valid_out = 0; wb_wr_en_out = 0.
- Accept = in_valid_in & in_ready_out. Transfer = out_valid_out & out_ready_in.
- Selection happens at accept: the selected data is captured; the select code is not stored.
  - sel < NUM_SRC: capture source[sel].
  - sel >= NUM_SRC: capture source 0 and set illegal_sel_out. The flag is cleared only by reset.
- Storage: main register (drives the outputs) plus one skid register.
  - in_ready_out = !skid_valid, driven from a register with no combinational path from out_ready_in.
  - out_valid_out = main_valid.
- Per-edge rules when flush_in = 0:
  - Accept, and main is empty or transferring: the entry goes to main; if the skid is full, the skid moves to main first and the new entry goes to the skid.
  - Accept while main is held (no transfer): the entry goes to the skid.
  - Transfer without accept: the skid (if valid) moves to main, otherwise main_valid becomes 0.
  - Entries leave in strict FIFO order.
- Latency: 1 cycle from accept to out_valid_out when the buffer is empty. Full throughput is 1 entry per cycle while out_ready_in = 1.
- flush_in = 1: at the next edge both valid bits clear and in_ready_out = 1. Flush has priority over an accept in the same cycle, so that entry is dropped. The illegal flag is still set if the dropped entry carried an illegal select. A transfer in the flush cycle still completes.
- wb_wr_en_out = main_valid & stored rd_wr_en & (stored rd != 0). Writes to x0 are suppressed, but the entry still handshakes.
- alu_2nd_src_out = alu_source_in ? rs2_in : imm_in. Purely combinational, independent of the buffer and of reset.
- Reset asserted mid-stream: all in-flight entries are lost and no wb_wr_en_out pulse is produced.

Test Plan:
- Reset, then 4 back-to-back accepts with sel=0..3, distinct sources (e.g. 0x11,0x22,0x33,0x44), out_ready_in=1 -> out_valid_out from cycle 1, wb_data_out 0x11,0x22,0x33,0x44 on consecutive cycles, in_ready_out stays 1.
- out_ready_in=0 with 3 offered entries -> main and skid fill, in_ready_out=0 after the 2nd accept, 3rd entry held upstream; release out_ready_in -> 3 entries delivered in order, none lost or duplicated.
- NUM_SRC=6, sel=7, source0=0xDEADBEEF -> wb_data_out=0xDEADBEEF, illegal_sel_out=1 and it remains 1 through later legal traffic until reset.
- Skid full, then flush_in=1 together with in_valid_in=1 -> next cycle out_valid_out=0, in_ready_out=1, flushed entry never appears.
- Entry with rd=0 and rd_wr_en=1 -> out_valid_out=1, wb_wr_en_out=0. Same entry with rd=5 -> wb_wr_en_out=1, wb_rd_addr_out=5.
- alu_source_in toggled with rs2=0xA5A5A5A5, imm=0x00000FFF, including while reset is asserted -> alu_2nd_src_out follows in the same cycle.
